// File: rtl/input_loader_if.sv
// Stream-in / buffer-write bundle between control, the input stream and the
// weight/image buffers, as seen by the input loader.
interface input_loader_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              read_enable;
    logic              img_weight_sel;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              wgt_we;
    logic              img_we;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_wdata;
    logic              finish_read;
    logic              busy;

    modport master (
        output read_enable, img_weight_sel, in_valid, in_data,
        input  in_ready, wgt_we, img_we, buf_addr, buf_wdata, finish_read, busy
    );

    modport slave (
        input  read_enable, img_weight_sel, in_valid, in_data,
        output in_ready, wgt_we, img_we, buf_addr, buf_wdata, finish_read, busy
    );
endinterface

// File: rtl/input_loader.sv
// Loads one weight kernel or one image tile from a valid/ready stream into
// the selected on-chip buffer, then reports completion to control.
module input_loader #(
    parameter int DATA_W       = 8,
    parameter int WEIGHT_WORDS = 9,
    parameter int IMG_WORDS    = 64,
    parameter int ADDR_W       = 6
) (
    input  logic          clk,
    input  logic          rst,
    input_loader_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_DONE     = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] WGT_LAST = ADDR_W'(WEIGHT_WORDS - 1);
    localparam logic [ADDR_W-1:0] IMG_LAST = ADDR_W'(IMG_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              sel_q, sel_d;

    logic              wgt_we_q, wgt_we_d;
    logic              img_we_q, img_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              finish_q, finish_d;
    logic              busy_q, busy_d;

    logic              in_ready_s;
    logic              hs_s;

    // in_ready depends on state only so the stream never sees a loop through in_valid.
    assign in_ready_s = (state_q == S_LOAD);
    assign hs_s       = bus.in_valid & in_ready_s;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        last_d   = last_q;
        sel_d    = sel_q;
        wgt_we_d = 1'b0;
        img_we_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.read_enable) begin
                    sel_d   = bus.img_weight_sel;
                    last_d  = bus.img_weight_sel ? WGT_LAST : IMG_LAST;
                    count_d = {ADDR_W{1'b0}};
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!bus.read_enable) begin
                    count_d = {ADDR_W{1'b0}};
                    state_d = S_IDLE;
                end else if (hs_s && (count_q == last_q)) begin
                    state_d = S_DONE;
                end else if (hs_s) begin
                    count_d = count_q + ADDR_W'(1);
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (!bus.read_enable) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_REL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted word is written even in the cycle control aborts.
        if (hs_s) begin
            wgt_we_d = sel_q;
            img_we_d = ~sel_q;
            addr_d   = count_q;
            wdata_d  = bus.in_data;
        end else begin
            wgt_we_d = 1'b0;
            img_we_d = 1'b0;
        end

        finish_d = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            count_q <= {ADDR_W{1'b0}};
            last_q  <= {ADDR_W{1'b0}};
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
        end
    end

    // Registered buffer-write and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wgt_we_q <= 1'b0;
            img_we_q <= 1'b0;
            addr_q   <= {ADDR_W{1'b0}};
            wdata_q  <= {DATA_W{1'b0}};
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wgt_we_q <= wgt_we_d;
            img_we_q <= img_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            finish_q <= finish_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.wgt_we      = wgt_we_q;
    assign bus.img_we      = img_we_q;
    assign bus.buf_addr    = addr_q;
    assign bus.buf_wdata   = wdata_q;
    assign bus.finish_read = finish_q;
    assign bus.busy        = busy_q;

endmodule
